// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first,
// with the carry held in a register between bits and a start/done handshake.
module serial_adder_fsm #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_s_sh;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_x;
    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_last;
    logic [WIDTH-1:0] w_s_full;

    // 1-bit full adder cell fed from the operand LSBs and the registered carry
    assign w_fa_x   = r_a_sh[0] ^ r_b_sh[0];
    assign w_fa_s   = w_fa_x ^ r_c;
    assign w_fa_c   = (r_a_sh[0] & r_b_sh[0]) | (w_fa_x & r_c);

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_s_full = {w_fa_s, r_s_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // busy/done are registered copies of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_s_sh <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == RUN);
            r_done <= (w_state_next == DONE);
            if (w_accept) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_c    <= cin;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_a_sh <= r_a_sh >> 1;
                r_b_sh <= r_b_sh >> 1;
                r_s_sh <= w_s_full[WIDTH-1:1];
                r_c    <= w_fa_c;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_sum  <= w_s_full;
                    r_cout <= w_fa_c;
                    r_ovf  <= r_c ^ w_fa_c;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Bench for serial_adder_fsm: a 64-bit and a 4-bit instance checked every cycle
// against a transaction-level timing/arithmetic model plus directed literals.
module tb_serial_adder_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s64, c64, busy64, done64, cout64, ovf64;
    logic [63:0] a64, b64, sum64;
    logic        s4, c4, busy4, done4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_adder_fsm #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(s64), .a(a64), .b(b64), .cin(c64),
        .busy(busy64), .done(done64), .sum(sum64), .cout(cout64), .ovf(ovf64)
    );

    serial_adder_fsm #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {ovf, cout, sum} of a w-bit add
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic c);
        logic [63:0] mask;
        logic [64:0] full;
        logic [63:0] s;
        logic        co;
        logic        ov;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    // Model: accepted op stays busy for w edges, then done for one cycle, then idle
    int          m_rem[2];
    bit          m_indone[2];
    logic        m_busy[2];
    logic        m_done[2];
    logic [63:0] m_sum[2];
    logic        m_cout[2];
    logic        m_ovf[2];
    logic [65:0] m_pend[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_indone[k] = 1'b0; m_busy[k] = 1'b0; m_done[k] = 1'b0;
            m_sum[k] = '0; m_cout[k] = 1'b0; m_ovf[k] = 1'b0; m_pend[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input int w, input logic st, input logic [63:0] a,
                              input logic [63:0] b, input logic c);
        if (m_indone[k]) begin
            m_indone[k] = 1'b0;
            m_done[k]   = 1'b0;
        end else if (m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
                m_busy[k]   = 1'b0;
                m_done[k]   = 1'b1;
                m_indone[k] = 1'b1;
                m_sum[k]    = m_pend[k][63:0];
                m_cout[k]   = m_pend[k][64];
                m_ovf[k]    = m_pend[k][65];
                $display("TXN w=%0d sum=0x%0h cout=%0b ovf=%0b", w, m_sum[k], m_cout[k], m_ovf[k]);
            end
        end else if (st) begin
            m_pend[k] = ref_add(w, a, b, c);
            m_rem[k]  = w;
            m_busy[k] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            cyc++;
            model_step(0, 64, s64, a64, b64, c64);
            model_step(1, 4, s4, {60'd0, a4}, {60'd0, b4}, c4);
        end
        #1;
        check("busy64", {63'd0, busy64}, {63'd0, m_busy[0]});
        check("done64", {63'd0, done64}, {63'd0, m_done[0]});
        check("sum64",  sum64, m_sum[0]);
        check("cout64", {63'd0, cout64}, {63'd0, m_cout[0]});
        check("ovf64",  {63'd0, ovf64},  {63'd0, m_ovf[0]});
        check("busy4",  {63'd0, busy4},  {63'd0, m_busy[1]});
        check("done4",  {63'd0, done4},  {63'd0, m_done[1]});
        check("sum4",   {60'd0, sum4},   m_sum[1]);
        check("cout4",  {63'd0, cout4},  {63'd0, m_cout[1]});
        check("ovf4",   {63'd0, ovf4},   {63'd0, m_ovf[1]});
    end

    task automatic go64(input logic [63:0] a, input logic [63:0] b, input logic c);
        @(negedge clk);
        s64 = 1'b1; a64 = a; b64 = b; c64 = c;
        @(negedge clk);
        s64 = 1'b0; a64 = ~a; b64 = {$urandom, $urandom}; c64 = ~c;
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge clk);
        s4 = 1'b1; a4 = a; b4 = b; c4 = c;
        @(negedge clk);
        s4 = 1'b0; a4 = ~a; b4 = 4'($urandom); c4 = ~c;
    endtask

    // Waits at negedges for done on instance k (0: 64-bit, 1: 4-bit)
    task automatic wait_done(input int k, input int budget, output int busy_cycles);
        bit ok;
        ok = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if ((k == 0) ? done64 : done4) begin
                ok = 1'b1;
                break;
            end
            if ((k == 0) ? busy64 : busy4) busy_cycles++;
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_done%0d actual=timeout required=done within %0d cycles", k, budget);
        end
    endtask

    int bc;
    int t1, t2;
    int ndone;
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] rexp;

    initial begin
        rst_n = 1'b1;
        s64 = 1'b0; a64 = '0; b64 = '0; c64 = 1'b0;
        s4  = 1'b0; a4  = '0; b4  = '0; c4  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy64", {63'd0, busy64}, 64'd0);
        check("rst_done64", {63'd0, done64}, 64'd0);
        check("rst_sum64",  sum64, 64'd0);
        check("rst_busy4",  {63'd0, busy4}, 64'd0);
        rst_n = 1'b1;

        // basic add
        go64(64'h5, 64'h3, 1'b0);
        wait_done(0, 200, bc);
        check("basic_busy_cycles", 64'(bc), 64'd64);
        check("basic_sum",  sum64, 64'h8);
        check("basic_cout", {63'd0, cout64}, 64'd0);
        check("basic_ovf",  {63'd0, ovf64},  64'd0);
        @(negedge clk);
        check("basic_done_one_cycle", {63'd0, done64}, 64'd0);

        // full carry ripple
        go64(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_done(0, 200, bc);
        check("ripple_sum",  sum64, 64'h0);
        check("ripple_cout", {63'd0, cout64}, 64'd1);
        check("ripple_ovf",  {63'd0, ovf64},  64'd0);

        // signed overflow
        go64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_done(0, 200, bc);
        check("ovf_sum",  sum64, 64'h8000_0000_0000_0000);
        check("ovf_cout", {63'd0, cout64}, 64'd0);
        check("ovf_ovf",  {63'd0, ovf64},  64'd1);

        // start while busy is ignored
        go64(64'h1, 64'h1, 1'b0);
        repeat (10) @(negedge clk);
        s64 = 1'b1; a64 = 64'hAAAA_AAAA_AAAA_AAAA; b64 = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        s64 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 120; i++) begin
            if (done64) ndone++;
            @(negedge clk);
        end
        check("busy_start_done_count", 64'(ndone), 64'd1);
        check("busy_start_sum", sum64, 64'h2);

        // asynchronous reset mid-operation
        go64(64'h9, 64'h9, 1'b0);
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy64}, 64'd0);
        check("arst_done", {63'd0, done64}, 64'd0);
        check("arst_sum",  sum64, 64'd0);
        check("arst_cout", {63'd0, cout64}, 64'd0);
        check("arst_ovf",  {63'd0, ovf64},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        go64(64'd10, 64'd20, 1'b0);
        wait_done(0, 200, bc);
        check("post_rst_busy_cycles", 64'(bc), 64'd64);
        check("post_rst_sum", sum64, 64'd30);

        // WIDTH=4 back-to-back with start held high
        @(negedge clk);
        s4 = 1'b1; a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
        wait_done(1, 20, bc);
        t1 = cyc;
        check("b2b_sum0",  {60'd0, sum4}, 64'h0);
        check("b2b_cout0", {63'd0, cout4}, 64'd1);
        check("b2b_ovf0",  {63'd0, ovf4},  64'd0);
        a4 = 4'h3; b4 = 4'h4;
        @(negedge clk);
        wait_done(1, 20, bc);
        t2 = cyc;
        s4 = 1'b0;
        check("b2b_spacing", 64'(t2 - t1), 64'd6);
        check("b2b_sum1",  {60'd0, sum4}, 64'h7);
        check("b2b_cout1", {63'd0, cout4}, 64'd0);

        // random WIDTH=4 vectors
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rc = 1'($urandom_range(1));
            rexp = {1'b0, ra} + {1'b0, rb} + {4'd0, rc};
            go4(ra, rb, rc);
            wait_done(1, 20, bc);
            check("rand4", {59'd0, cout4, sum4}, {59'd0, rexp});
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
